irrigation_zone_sequencer: RTL and testbench

- Clocked, parametrised successor to the combinational single-bed irrigation controller.
- Monitors the three-level water tank with debounced sensors and detects inconsistent sensor readings.
- Drives the alarm and a hysteretic inlet valve.
- Sequences ZONES irrigation zones round-robin with timed sprinkler or drip watering; a downstream display block consumes the state, zone and mode outputs.

---
 rtl/irrigation_zone_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_irrigation_zone_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_sequencer.sv
// Irrigation zone sequencer: debounced tank monitoring, inlet valve hysteresis,
// alarm/error flags and round-robin timed watering of ZONES soil zones.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   high/middle/low        tank level sensors (1 = water present)
//   umidadeDoSolo[ZONES]   per-zone soil sensor (1 = dry, wants water)
//   umidadeDoAr            1 = humid air
//   temperatura            1 = hot
//   enable                 irrigation enable
//   erro                   inconsistent tank sensors (registered)
//   saidaDoAlarme          alarm (registered)
//   ValvulaDeEntrada       tank inlet valve (registered, hysteretic)
//   ValvulaDeAspersao      one-hot sprinkler valves (decoded from state)
//   ValvulaDeGotejamento   one-hot drip valves (decoded from state)
//   zona_ativa             zone watering now or last watered
//   estado                 FSM state code
//   ocupado                FSM in WATER or SETTLE
module irrigation_zone_sequencer #(
  parameter int unsigned ZONES        = 4,
  parameter int unsigned ZW           = 2,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DEB_TICKS    = 4,
  parameter int unsigned WATER_TICKS  = 60,
  parameter int unsigned SETTLE_TICKS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             high,
  input  logic             middle,
  input  logic             low,
  input  logic [ZONES-1:0] umidadeDoSolo,
  input  logic             umidadeDoAr,
  input  logic             temperatura,
  input  logic             enable,
  output logic             erro,
  output logic             saidaDoAlarme,
  output logic             ValvulaDeEntrada,
  output logic [ZONES-1:0] ValvulaDeAspersao,
  output logic [ZONES-1:0] ValvulaDeGotejamento,
  output logic [ZW-1:0]    zona_ativa,
  output logic [1:0]       estado,
  output logic             ocupado
);

  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW    = $clog2(DEB_TICKS + 1);
  localparam int unsigned NDEB  = 3 + ZONES;
  localparam int unsigned NSYNC = NDEB + 3;
  localparam int unsigned TMAX  = (WATER_TICKS > SETTLE_TICKS) ? WATER_TICKS : SETTLE_TICKS;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WATER  = 2'b01,
    SETTLE = 2'b10,
    FAULT  = 2'b11
  } state_t;

  // Two-flop synchronisers for every input
  logic [NSYNC-1:0] raw, sync1, sync2;
  assign raw = {enable, temperatura, umidadeDoAr, umidadeDoSolo, low, middle, high};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  logic air, temp, en;
  assign air  = sync2[NDEB];
  assign temp = sync2[NDEB+1];
  assign en   = sync2[NDEB+2];

  // Timing tick prescaler
  logic [PW-1:0] pre_cnt;
  logic          tick;
  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  // Debounce of levels and soil bits; stable copy follows raw after DEB_TICKS differing ticks
  logic [NDEB-1:0] stable;
  logic [DW-1:0]   deb_cnt [NDEB];

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NDEB; i++) deb_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NDEB; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Valid flag: debounced values are trustworthy DEB_TICKS ticks after reset
  logic [DW-1:0] vcnt;
  logic          valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      vcnt  <= '0;
      valid <= 1'b0;
    end else if (tick && !valid) begin
      if (vcnt == DW'(DEB_TICKS - 1)) valid <= 1'b1;
      else                            vcnt  <= vcnt + DW'(1);
    end
  end

  logic             h, m, l;
  logic [ZONES-1:0] dry;
  assign h   = stable[0];
  assign m   = stable[1];
  assign l   = stable[2];
  assign dry = stable[NDEB-1:3];

  // Tank supervision: error, alarm and inlet hysteresis
  logic err_c, alarm_c;
  assign err_c   = valid & ((h & ~m) | (m & ~l));
  assign alarm_c = valid & (~l | err_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      erro             <= 1'b0;
      saidaDoAlarme    <= 1'b0;
      ValvulaDeEntrada <= 1'b0;
    end else begin
      erro          <= err_c;
      saidaDoAlarme <= alarm_c;
      if (!valid || h || err_c) ValvulaDeEntrada <= 1'b0;
      else if (!m)              ValvulaDeEntrada <= 1'b1;
    end
  end

  logic auth_c;
  assign auth_c = valid & ~saidaDoAlarme & en;

  // Round-robin pick: first dry zone at or after ptr, wrapping
  logic [ZW-1:0] ptr;
  logic [ZW-1:0] pick_zone;
  logic          pick_found;

  always_comb begin
    pick_found = 1'b0;
    pick_zone  = '0;
    for (int i = 0; i < ZONES; i++) begin
      int unsigned idx;
      idx = 32'(ptr) + 32'(i);
      if (idx >= ZONES) idx = idx - ZONES;
      if (!pick_found && dry[ZW'(idx)]) begin
        pick_found = 1'b1;
        pick_zone  = ZW'(idx);
      end
    end
  end

  // Sequencer FSM
  state_t        state, state_nxt;
  logic [ZW-1:0] zone, zone_nxt, ptr_nxt, zone_inc;
  logic          mode, mode_nxt;
  logic [TW-1:0] timer, timer_nxt;

  assign zone_inc = (zone == ZW'(ZONES - 1)) ? '0 : zone + ZW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      zone  <= '0;
      ptr   <= '0;
      mode  <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      zone  <= zone_nxt;
      ptr   <= ptr_nxt;
      mode  <= mode_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    zone_nxt  = zone;
    ptr_nxt   = ptr;
    mode_nxt  = mode;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (tick && auth_c && pick_found) begin
          state_nxt = WATER;
          zone_nxt  = pick_zone;
          // ptr parks on the zone so an interrupted visit is retried first
          ptr_nxt   = pick_zone;
          mode_nxt  = temp & ~air & m;
          timer_nxt = TW'(WATER_TICKS);
        end
      end
      WATER: begin
        if (saidaDoAlarme || erro) begin
          state_nxt = FAULT;
        end else if (!en) begin
          state_nxt = IDLE;
        end else if (!dry[zone] || (tick && timer == TW'(1))) begin
          state_nxt = SETTLE;
          timer_nxt = TW'(SETTLE_TICKS);
          ptr_nxt   = zone_inc;
        end else if (tick) begin
          timer_nxt = timer - TW'(1);
        end
      end
      SETTLE: begin
        if (saidaDoAlarme) begin
          state_nxt = FAULT;
        end else if (tick) begin
          if (timer == TW'(1)) state_nxt = IDLE;
          else                 timer_nxt = timer - TW'(1);
        end
      end
      FAULT: begin
        if (!saidaDoAlarme) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valve decode straight from registered state so valves track state with no lag
  always_comb begin
    ValvulaDeAspersao    = '0;
    ValvulaDeGotejamento = '0;
    if (state == WATER) begin
      if (mode) ValvulaDeAspersao[zone]    = 1'b1;
      else      ValvulaDeGotejamento[zone] = 1'b1;
    end
  end

  assign zona_ativa = zone;
  assign estado     = state;
  assign ocupado    = (state == WATER) || (state == SETTLE);

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Self-checking bench for irrigation_zone_sequencer: scoreboard of expected
// watering visits plus direct checks of tank supervision outputs.
module tb_irrigation_zone_sequencer;

  localparam int unsigned ZONES        = 4;
  localparam int unsigned ZW           = 2;
  localparam int unsigned TICK_DIV     = 2;
  localparam int unsigned DEB_TICKS    = 2;
  localparam int unsigned WATER_TICKS  = 4;
  localparam int unsigned SETTLE_TICKS = 2;
  localparam int          FULL         = WATER_TICKS * TICK_DIV;

  logic             clk = 1'b0;
  logic             reset;
  logic             high, middle, low;
  logic [ZONES-1:0] soil;
  logic             air, temp, enable;
  logic             erro, alarm, inlet;
  logic [ZONES-1:0] asp, gote;
  logic [ZW-1:0]    zona;
  logic [1:0]       estado;
  logic             ocupado;

  irrigation_zone_sequencer #(
    .ZONES(ZONES), .ZW(ZW), .TICK_DIV(TICK_DIV), .DEB_TICKS(DEB_TICKS),
    .WATER_TICKS(WATER_TICKS), .SETTLE_TICKS(SETTLE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .high(high), .middle(middle), .low(low),
    .umidadeDoSolo(soil), .umidadeDoAr(air), .temperatura(temp), .enable(enable),
    .erro(erro), .saidaDoAlarme(alarm), .ValvulaDeEntrada(inlet),
    .ValvulaDeAspersao(asp), .ValvulaDeGotejamento(gote),
    .zona_ativa(zona), .estado(estado), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   zone;
    logic spr;
    int   dmin;
    int   dmax;
    int   end_state;
    int   zafter;
  } visit_t;

  visit_t sb[$];
  visit_t cur;
  logic   cur_valid = 1'b0;
  int     n_checks = 0, n_errors = 0;
  int     n_open = 0, n_close = 0, t_open = 0, cyc = 0;
  logic [2*ZONES-1:0] prev_v = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push(int zone, logic spr, int dmin, int dmax, int es, int za);
    visit_t e;
    e.zone = zone; e.spr = spr; e.dmin = dmin; e.dmax = dmax;
    e.end_state = es; e.zafter = za;
    sb.push_back(e);
  endfunction

  // Visit monitor: every valve change opens/closes a visit against the scoreboard
  always @(negedge clk) begin
    logic [2*ZONES-1:0] v;
    int zi;
    cyc++;
    v = {asp, gote};
    if (v !== prev_v) begin
      check("valves_onehot", 32'($countones(v) <= 1), 32'd1);
      if (prev_v != '0) begin
        n_close++;
        if (cur_valid) begin
          check("visit_dur_min", 32'((cyc - t_open) >= cur.dmin), 32'd1);
          check("visit_dur_max", 32'((cyc - t_open) <= cur.dmax), 32'd1);
          check("visit_end_state", 32'(estado), 32'(cur.end_state));
          check("zona_after_visit", 32'(zona), 32'(cur.zafter));
          cur_valid = 1'b0;
        end
      end
      if (v != '0) begin
        n_open++;
        t_open = cyc;
        zi = 0;
        for (int i = 0; i < ZONES; i++) if (asp[i] || gote[i]) zi = i;
        if (sb.size() == 0) begin
          check("unexpected_visit", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          cur_valid = 1'b1;
          check("visit_zone", 32'(zi), 32'(cur.zone));
          check("visit_sprinkler", 32'(|asp), 32'(cur.spr));
          check("visit_zona_ativa", 32'(zona), 32'(cur.zone));
          check("visit_estado", 32'(estado), 32'd1);
          check("visit_ocupado", 32'(ocupado), 32'd1);
        end
      end
      prev_v = v;
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_open(input int target);
    int k = 0;
    while (n_open < target && k < 400) begin @(posedge clk); k++; end
    check("wait_open", 32'(n_open >= target), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_close(input int target);
    int k = 0;
    while (n_close < target && k < 400) begin @(posedge clk); k++; end
    check("wait_close", 32'(n_close >= target), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; high = 1'b1; middle = 1'b1; low = 1'b1;
    soil = '0; air = 1'b0; temp = 1'b0; enable = 1'b0;

    // Reset state
    settle(4);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_inlet", 32'(inlet), 32'd0);
    check("rst_asp", 32'(asp), 32'd0);
    check("rst_gote", 32'(gote), 32'd0);
    check("rst_zona", 32'(zona), 32'd0);
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b0;

    // Outputs gated until debounced values are valid
    settle(2);
    check("prevalid_alarm", 32'(alarm), 32'd0);
    check("prevalid_inlet", 32'(inlet), 32'd0);
    settle(12);
    check("full_erro", 32'(erro), 32'd0);
    check("full_alarm", 32'(alarm), 32'd0);
    check("full_inlet", 32'(inlet), 32'd0);
    check("full_estado", 32'(estado), 32'd0);

    // Inlet hysteresis
    high = 1'b0; middle = 1'b0;
    settle(12);
    check("low_only_inlet", 32'(inlet), 32'd1);
    check("low_only_alarm", 32'(alarm), 32'd0);
    check("low_only_erro", 32'(erro), 32'd0);
    middle = 1'b1;
    settle(12);
    check("mid_rise_inlet", 32'(inlet), 32'd1);
    high = 1'b1;
    settle(12);
    check("high_inlet", 32'(inlet), 32'd0);
    high = 1'b0;
    settle(12);
    check("high_fall_hold_inlet", 32'(inlet), 32'd0);
    middle = 1'b0;
    settle(12);
    check("mid_fall_inlet", 32'(inlet), 32'd1);
    high = 1'b1; middle = 1'b1;
    settle(12);
    check("refill_inlet", 32'(inlet), 32'd0);

    // Round-robin sprinkler over zones 1 and 3, wrapping back to 1
    temp = 1'b1; air = 1'b0;
    settle(6);
    push(1, 1'b1, FULL, FULL, 2, 1);
    push(3, 1'b1, FULL, FULL, 2, 3);
    push(1, 1'b1, FULL, FULL, 2, 1);
    enable = 1'b1; soil = 4'b1010;
    wait_close(3);
    enable = 1'b0; soil = '0;
    settle(12);
    check("rr_idle_estado", 32'(estado), 32'd0);
    check("rr_idle_ocupado", 32'(ocupado), 32'd0);
    check("rr_zona_hold", 32'(zona), 32'd1);

    // Drip with early end when the zone turns wet (ptr 2 wraps to zone 0)
    temp = 1'b0;
    push(0, 1'b0, 1, FULL - 1, 2, 0);
    enable = 1'b1; soil = 4'b0001;
    wait_open(4);
    soil = '0;
    wait_close(4);
    settle(12);
    check("drip_idle_estado", 32'(estado), 32'd0);

    // Alarm mid-watering; zone 2 chosen proves ptr advanced to 1
    push(2, 1'b0, 1, FULL, 3, 2);
    soil = 4'b0101;
    wait_open(5);
    low = 1'b0;
    wait_close(5);
    check("lowfault_alarm", 32'(alarm), 32'd1);
    check("lowfault_erro", 32'(erro), 32'd1);
    check("lowfault_inlet", 32'(inlet), 32'd0);
    push(2, 1'b0, FULL, FULL, 2, 2);
    low = 1'b1;
    wait_close(6);
    enable = 1'b0; soil = '0;
    settle(16);
    check("retry_idle_estado", 32'(estado), 32'd0);

    // Inconsistent sensors (high without middle) while watering
    push(2, 1'b0, 1, FULL, 3, 2);
    enable = 1'b1; soil = 4'b0100;
    wait_open(7);
    middle = 1'b0;
    wait_close(7);
    check("incons_erro", 32'(erro), 32'd1);
    check("incons_alarm", 32'(alarm), 32'd1);
    check("incons_inlet", 32'(inlet), 32'd0);
    enable = 1'b0; soil = '0; middle = 1'b1;
    settle(16);
    check("incons_clear_estado", 32'(estado), 32'd0);
    check("incons_clear_erro", 32'(erro), 32'd0);
    check("incons_clear_alarm", 32'(alarm), 32'd0);

    // Enable dropped mid-watering returns straight to IDLE
    push(3, 1'b0, 1, FULL - 1, 0, 3);
    enable = 1'b1; soil = 4'b1000;
    wait_open(8);
    enable = 1'b0;
    wait_close(8);
    settle(4);
    check("enoff_estado", 32'(estado), 32'd0);

    // Reset mid-watering closes the valves on the next edge
    push(3, 1'b0, 1, FULL, 0, 0);
    enable = 1'b1;
    wait_open(9);
    reset = 1'b1;
    wait_close(9);
    check("midrst_asp", 32'(asp), 32'd0);
    check("midrst_gote", 32'(gote), 32'd0);
    check("midrst_estado", 32'(estado), 32'd0);
    check("midrst_alarm", 32'(alarm), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
